l1d_cache_nway: RTL and testbench
=================================

L1D_CACHE_NWAY -- requirements
Module: l1d_cache_nway

Interface
REQ-001 SHALL have parameter WAYS, default 2, associativity; legal values 2 and 4.
REQ-002 SHALL have parameter SETS, default 8, set count; power of two, 2..64.
REQ-003 SHALL fix the line at 256 bits, the offset at address[4:0], the index at log2(SETS) bits above the offset, and the tag as the remaining upper bits.
REQ-004 SHALL have ports as follows; clock and reset come first.
- clk  in  1  single clock; all state rising-edge.
- rst  in  1  asynchronous, active-high reset.
- mem_address  in  32  CPU byte address.
- mem_rdata  out  32  read word.
- mem_wdata  in  32  write word.
- mem_read  in  1  read request.
- mem_write  in  1  write request.
- mem_byte_enable  in  4  write byte lanes.
- mem_resp  out  1  one-cycle completion pulse.
- pmem_address  out  32  line address; bits [4:0] are 0.
- pmem_rdata  in  256  fill line.
- pmem_wdata  out  256  writeback line.
- pmem_read  out  1  fill request.
- pmem_write  out  1  writeback request.
- pmem_resp  in  1  pmem completion.
- hit_clear  in  1  zero the hit counter.
- miss_clear  in  1  zero the miss counter.
- hit_count  out  32  hit counter.
- miss_count  out  32  miss counter.

Function
REQ-005 SHALL implement an FSM with states IDLE, WRITEBACK and FILL.
REQ-006 IDLE with a request SHALL perform a combinational tag compare across all valid ways of the indexed set.
REQ-007 On a hit in IDLE the block SHALL assert mem_resp in the same cycle.
- Read hit: mem_rdata = word mem_address[4:2] of the hit line.
- Write hit: only the enabled bytes of that word are written at the clock edge, and the dirty bit is set.
REQ-008 Every hit SHALL update the set's replacement state to mark the hit way most-recently-used.
REQ-009 Victim selection SHALL take the lowest-index invalid way if any; otherwise the pseudo-LRU way.
- WAYS=2: one LRU bit per set.
- WAYS=4: 3-bit tree per set.
REQ-010 On a miss with a dirty victim the FSM SHALL go IDLE->WRITEBACK.
- pmem_write=1, pmem_address={victim tag, index, 5'b0}, pmem_wdata=victim line.
- Outputs are held until pmem_resp, then the FSM goes to FILL.
REQ-011 On a miss with a clean or invalid victim the FSM SHALL go IDLE->FILL directly.
REQ-012 FILL SHALL hold pmem_read=1 and pmem_address={request tag, index, 5'b0} until pmem_resp.
- On pmem_resp: line written into the victim way, valid=1, dirty=0, tag stored, return to IDLE.
REQ-013 After a fill, the request SHALL be completed as a hit in IDLE; that completion SHALL NOT increment hit_count.
REQ-014 mem_resp SHALL never be asserted outside IDLE.
- pmem_read and pmem_write SHALL never be asserted together.
REQ-015 The CPU holds address, data and request stable until mem_resp; the block SHALL NOT latch the request.
REQ-016 mem_read and mem_write asserted together SHALL be treated as a write.
REQ-017 hit_count SHALL increment once per first-lookup hit.
- miss_count SHALL increment once per miss, on the IDLE->WRITEBACK/FILL transition.
- Both counters saturate at 32'hFFFF_FFFF.
REQ-018 A clear input SHALL take priority over a same-cycle increment, leaving the counter at 0.
REQ-019 pmem_resp SHALL be ignored in IDLE.
REQ-020 When idle with no request, all outputs SHALL be 0 except the counters and mem_rdata, which is don't-care.

Reset
REQ-021 rst SHALL asynchronously force the FSM to IDLE and clear all valid, dirty and LRU bits and both counters.
REQ-022 rst SHALL asynchronously drive mem_resp=0, pmem_read=0 and pmem_write=0.
REQ-023 Data and tag arrays are not reset.
REQ-024 Reset during WRITEBACK or FILL SHALL abandon the transfer; no array update occurs from it.

Structure
REQ-025 A package l1d_cache_pkg SHALL hold:
- the FSM state enum;
- constants LINE_BITS=256 and OFFSET_BITS=5;
- a function computing index and tag widths from SETS.
REQ-026 Replacement logic SHALL be one sub-module, l1d_plru, parametrised by WAYS and SETS.
- Inputs: touch index, touch way, touch enable.
- Output: victim way for a read index.
REQ-027 Arrays SHALL be flop-based, with no memory macros.

Verification
REQ-028 Read-miss clean, WAYS=2: read 0x0000_0040 after reset.
- pmem_read with pmem_address=0x0000_0040; return line word0=0xDEADBEEF.
- Then mem_resp with mem_rdata=0xDEADBEEF; miss_count=1, hit_count=0.
REQ-029 Write-hit byte enable: line resident holding 0x11223344.
- Write 0xAABBCCDD with byte_enable=4'b0101.
- mem_resp same cycle; a subsequent read returns 0x11BB33DD; hit_count +1.
REQ-030 Dirty eviction, WAYS=2, SETS=8: fill 0x000, 0x100, 0x200 (all index 0), with 0x000 made dirty.
- Access 0x200: pmem_write to 0x0000_0000 precedes pmem_read to 0x0000_0200.
REQ-031 PLRU, WAYS=4: fill 4 ways of index 0, then touch ways 0,1,2,3 in order.
- A 5th tag evicts way 0.
REQ-032 Counter rules:
- hit_clear together with a hit leaves hit_count=0.
- miss_count forced to 0xFFFF_FFFF stays there on a further miss.
REQ-033 Reset in FILL: assert rst while pmem_read=1.
- pmem_read drops without waiting for a clock edge.
- A subsequent read of the same address misses again.

Source files
------------

// File: rtl/l1d_cache_pkg.sv
// Shared types and geometry helpers for the N-way L1 data cache.
// Address layout is {tag, index, 5-bit line offset} over a 32-bit byte address.
package l1d_cache_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FILL      = 2'd2
  } state_t;

  localparam int LINE_BITS   = 256;
  localparam int OFFSET_BITS = 5;

  typedef struct packed {
    logic [7:0] index_w;
    logic [7:0] tag_w;
  } widths_t;

  function automatic widths_t addr_widths(input int sets);
    widths_t w;
    w.index_w = 8'($clog2(sets));
    w.tag_w   = 8'(32 - OFFSET_BITS - $clog2(sets));
    return w;
  endfunction

endpackage

// File: rtl/l1d_plru.sv
// Per-set pseudo-LRU state: one bit for 2 ways, a 3-bit tree for 4 ways.
// Tree bits point toward the side to evict next; a touch points them away.
module l1d_plru
  import l1d_cache_pkg::*;
#(
  parameter int WAYS = 2,
  parameter int SETS = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [$clog2(SETS)-1:0] touch_index,
  input  logic [$clog2(WAYS)-1:0] touch_way,
  input  logic                    touch_en,
  input  logic [$clog2(SETS)-1:0] read_index,
  output logic [$clog2(WAYS)-1:0] victim
);

  localparam int TREE_W = WAYS - 1;

  logic [TREE_W-1:0] tree_reg [SETS];
  logic [TREE_W-1:0] tree_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) tree_reg[s] <= '0;
    end else if (touch_en) begin
      tree_reg[touch_index] <= tree_next;
    end
  end

  generate
    if (WAYS == 2) begin : g_two
      assign tree_next = ~touch_way;
      assign victim    = tree_reg[read_index];
    end else begin : g_four
      logic [2:0] cur;
      always_comb begin
        tree_next    = tree_reg[touch_index];
        tree_next[0] = ~touch_way[1];
        if (touch_way[1]) tree_next[2] = ~touch_way[0];
        else              tree_next[1] = ~touch_way[0];
      end
      assign cur    = tree_reg[read_index];
      assign victim = cur[0] ? {1'b1, cur[2]} : {1'b0, cur[1]};
    end
  endgenerate

endmodule

// File: rtl/l1d_cache_nway.sv
// Write-back, write-allocate N-way set-associative L1 data cache with
// 256-bit lines, pseudo-LRU replacement and saturating hit/miss counters.
module l1d_cache_nway
  import l1d_cache_pkg::*;
#(
  parameter int WAYS = 2,
  parameter int SETS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          mem_address,
  output logic [31:0]          mem_rdata,
  input  logic [31:0]          mem_wdata,
  input  logic                 mem_read,
  input  logic                 mem_write,
  input  logic [3:0]           mem_byte_enable,
  output logic                 mem_resp,
  output logic [31:0]          pmem_address,
  input  logic [LINE_BITS-1:0] pmem_rdata,
  output logic [LINE_BITS-1:0] pmem_wdata,
  output logic                 pmem_read,
  output logic                 pmem_write,
  input  logic                 pmem_resp,
  input  logic                 hit_clear,
  input  logic                 miss_clear,
  output logic [31:0]          hit_count,
  output logic [31:0]          miss_count
);

  localparam widths_t AW    = addr_widths(SETS);
  localparam int      IDX_W = int'(AW.index_w);
  localparam int      TAG_W = int'(AW.tag_w);
  localparam int      WAY_W = $clog2(WAYS);

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] req_tag;
  logic [2:0]       word_sel;
  logic             request;

  assign idx      = mem_address[OFFSET_BITS +: IDX_W];
  assign req_tag  = mem_address[31 -: TAG_W];
  assign word_sel = mem_address[4:2];
  assign request  = mem_read | mem_write;

  logic [LINE_BITS-1:0] way_line [WAYS];
  logic [TAG_W-1:0]     way_tag  [WAYS];
  logic [SETS-1:0]      valid_reg [WAYS];
  logic [SETS-1:0]      dirty_reg [WAYS];

  state_t           state_reg, state_next;
  logic [WAY_W-1:0] victim_reg, victim_way, plru_victim, hit_way;
  logic [WAYS-1:0]  hit_vec;
  logic             hit, lookup_hit, write_hit, fill_we, miss_event;
  logic             fill_done_reg;
  logic [LINE_BITS-1:0] hit_line;
  logic [31:0]      hit_word, merged_word;
  logic [31:0]      hit_count_reg, miss_count_reg;

  // Tag compare, hit select and victim choice (lowest invalid way wins over PLRU)
  always_comb begin
    hit_vec    = '0;
    hit_way    = '0;
    victim_way = plru_victim;
    for (int w = 0; w < WAYS; w++) begin
      hit_vec[w] = valid_reg[w][idx] && (way_tag[w] == req_tag);
      if (hit_vec[w]) hit_way = WAY_W'(w);
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_reg[w][idx]) victim_way = WAY_W'(w);
    end
  end

  assign hit      = |hit_vec;
  assign hit_line = way_line[hit_way];
  assign hit_word = hit_line[{word_sel, 5'b0} +: 32];
  assign mem_rdata = hit_word;

  always_comb begin
    merged_word = hit_word;
    for (int b = 0; b < 4; b++) begin
      if (mem_byte_enable[b]) merged_word[b*8 +: 8] = mem_wdata[b*8 +: 8];
    end
  end

  assign lookup_hit = (state_reg == IDLE) && request && hit;
  // Gating with rst keeps an abandoned transfer from touching the arrays
  assign write_hit  = lookup_hit && mem_write && !rst;
  assign fill_we    = (state_reg == FILL) && pmem_resp && !rst;

  always_comb begin
    state_next   = state_reg;
    mem_resp     = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    miss_event   = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (request) begin
          if (hit) begin
            mem_resp = 1'b1;
          end else begin
            miss_event = 1'b1;
            state_next = (valid_reg[victim_way][idx] && dirty_reg[victim_way][idx])
                         ? WRITEBACK : FILL;
          end
        end
      end
      WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {way_tag[victim_reg], idx, 5'b0};
        pmem_wdata   = way_line[victim_reg];
        if (pmem_resp) state_next = FILL;
      end
      FILL: begin
        pmem_read    = 1'b1;
        pmem_address = {req_tag, idx, 5'b0};
        if (pmem_resp) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      victim_reg    <= '0;
      fill_done_reg <= 1'b0;
      for (int w = 0; w < WAYS; w++) begin
        valid_reg[w] <= '0;
        dirty_reg[w] <= '0;
      end
    end else begin
      state_reg <= state_next;
      if (miss_event) victim_reg <= victim_way;
      // Marks the post-fill completion so it is not counted as a hit
      if (fill_we)         fill_done_reg <= 1'b1;
      else if (lookup_hit) fill_done_reg <= 1'b0;
      if (fill_we) begin
        valid_reg[victim_reg][idx] <= 1'b1;
        dirty_reg[victim_reg][idx] <= 1'b0;
      end else if (write_hit) begin
        dirty_reg[hit_way][idx] <= 1'b1;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
      logic [LINE_BITS-1:0] data_mem [SETS];
      logic [TAG_W-1:0]     tag_mem  [SETS];
      always_ff @(posedge clk) begin
        if (fill_we && (victim_reg == WAY_W'(gi))) begin
          data_mem[idx] <= pmem_rdata;
          tag_mem[idx]  <= req_tag;
        end else if (write_hit && hit_vec[gi]) begin
          data_mem[idx][{word_sel, 5'b0} +: 32] <= merged_word;
        end
      end
      assign way_line[gi] = data_mem[idx];
      assign way_tag[gi]  = tag_mem[idx];
    end
  endgenerate

  l1d_plru #(
    .WAYS(WAYS),
    .SETS(SETS)
  ) u_plru (
    .clk        (clk),
    .rst        (rst),
    .touch_index(idx),
    .touch_way  (hit_way),
    .touch_en   (lookup_hit),
    .read_index (idx),
    .victim     (plru_victim)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count_reg  <= '0;
      miss_count_reg <= '0;
    end else begin
      if (hit_clear) hit_count_reg <= '0;
      else if (lookup_hit && !fill_done_reg && hit_count_reg != 32'hFFFF_FFFF)
        hit_count_reg <= hit_count_reg + 32'd1;
      if (miss_clear) miss_count_reg <= '0;
      else if (miss_event && miss_count_reg != 32'hFFFF_FFFF)
        miss_count_reg <= miss_count_reg + 32'd1;
    end
  end

  assign hit_count  = hit_count_reg;
  assign miss_count = miss_count_reg;

endmodule

// File: tb/tb_l1d_cache_nway.sv
// Directed bench: a 2-way and a 4-way cache instance behind a simple
// line-memory model; expected values are hand-derived per vector.
module tb_l1d_cache_nway;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [31:0]  mem_address = '0;
  logic [31:0]  mem_wdata = '0;
  logic [3:0]   mem_byte_enable = '0;
  logic [255:0] pmem_rdata = '0;

  logic         mem_read_s   [2] = '{1'b0, 1'b0};
  logic         mem_write_s  [2] = '{1'b0, 1'b0};
  logic         pmem_resp_s  [2] = '{1'b0, 1'b0};
  logic         hit_clear_s  [2] = '{1'b0, 1'b0};
  logic         miss_clear_s [2] = '{1'b0, 1'b0};
  logic         mem_resp_s   [2];
  logic         pmem_read_s  [2];
  logic         pmem_write_s [2];
  logic [31:0]  mem_rdata_s  [2];
  logic [31:0]  pmem_address_s [2];
  logic [255:0] pmem_wdata_s [2];
  logic [31:0]  hit_count_s  [2];
  logic [31:0]  miss_count_s [2];

  int n_checks = 0;
  int n_fail   = 0;

  logic [255:0] mem_model [logic [31:0]];
  logic [31:0]  last_rdata, last_wb_addr, last_fill_addr;
  int           last_cycles, wbs, fills;
  bit           wb_first;

  always #5 clk = ~clk;

  l1d_cache_nway #(.WAYS(2), .SETS(8)) dut0 (
    .clk(clk), .rst(rst), .mem_address(mem_address), .mem_rdata(mem_rdata_s[0]),
    .mem_wdata(mem_wdata), .mem_read(mem_read_s[0]), .mem_write(mem_write_s[0]),
    .mem_byte_enable(mem_byte_enable), .mem_resp(mem_resp_s[0]),
    .pmem_address(pmem_address_s[0]), .pmem_rdata(pmem_rdata), .pmem_wdata(pmem_wdata_s[0]),
    .pmem_read(pmem_read_s[0]), .pmem_write(pmem_write_s[0]), .pmem_resp(pmem_resp_s[0]),
    .hit_clear(hit_clear_s[0]), .miss_clear(miss_clear_s[0]),
    .hit_count(hit_count_s[0]), .miss_count(miss_count_s[0])
  );

  l1d_cache_nway #(.WAYS(4), .SETS(8)) dut1 (
    .clk(clk), .rst(rst), .mem_address(mem_address), .mem_rdata(mem_rdata_s[1]),
    .mem_wdata(mem_wdata), .mem_read(mem_read_s[1]), .mem_write(mem_write_s[1]),
    .mem_byte_enable(mem_byte_enable), .mem_resp(mem_resp_s[1]),
    .pmem_address(pmem_address_s[1]), .pmem_rdata(pmem_rdata), .pmem_wdata(pmem_wdata_s[1]),
    .pmem_read(pmem_read_s[1]), .pmem_write(pmem_write_s[1]), .pmem_resp(pmem_resp_s[1]),
    .hit_clear(hit_clear_s[1]), .miss_clear(miss_clear_s[1]),
    .hit_count(hit_count_s[1]), .miss_count(miss_count_s[1])
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Untouched lines hold their own word addresses: word k of line a is a|(k<<2)
  function automatic logic [255:0] get_line(input logic [31:0] a);
    logic [255:0] l;
    if (mem_model.exists(a)) return mem_model[a];
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = a | (k << 2);
    return l;
  endfunction

  // Starts just after a falling edge; returns just after a falling edge.
  task automatic access(input int d, input logic [31:0] addr, input logic rd, input logic wr,
                        input logic [31:0] wdata, input logic [3:0] be);
    bit done = 0;
    mem_address = addr; mem_wdata = wdata; mem_byte_enable = be;
    mem_read_s[d] = rd; mem_write_s[d] = wr;
    wbs = 0; fills = 0; wb_first = 0; last_cycles = -1;
    last_wb_addr = '1; last_fill_addr = '1; last_rdata = 'x;
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      #1;
      if (mem_resp_s[d]) begin
        last_rdata = mem_rdata_s[d]; last_cycles = cyc; done = 1;
        @(posedge clk); #1;
        mem_read_s[d] = 1'b0; mem_write_s[d] = 1'b0;
        @(negedge clk);
      end else begin
        if (pmem_write_s[d]) begin
          wbs++; last_wb_addr = pmem_address_s[d];
          if (fills == 0) wb_first = 1;
          mem_model[pmem_address_s[d]] = pmem_wdata_s[d];
          pmem_resp_s[d] = 1'b1;
        end else if (pmem_read_s[d]) begin
          fills++; last_fill_addr = pmem_address_s[d];
          pmem_rdata = get_line(pmem_address_s[d]);
          pmem_resp_s[d] = 1'b1;
        end
        @(negedge clk);
        pmem_resp_s[d] = 1'b0;
      end
    end
    if (!done) begin
      check_eq("access_timeout", 32'd0, 32'd1);
      mem_read_s[d] = 1'b0; mem_write_s[d] = 1'b0;
    end
    $display("dut%0d rd=%0b wr=%0b addr=%h rdata=%h cycles=%0d wb=%0d fill=%0d hits=%0d misses=%0d",
             d, rd, wr, addr, last_rdata, last_cycles, wbs, fills, hit_count_s[d], miss_count_s[d]);
  endtask

  task automatic pulse_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  initial begin
    logic [255:0] seed;
    seed = get_line(32'h40);
    seed[31:0] = 32'hDEAD_BEEF;
    mem_model[32'h40] = seed;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      check_eq("rst_hit_count", hit_count_s[d], 32'd0);
      check_eq("rst_miss_count", miss_count_s[d], 32'd0);
      check_eq("rst_idle_outs", {28'd0, mem_resp_s[d], pmem_read_s[d], pmem_write_s[d], 1'b0}, 32'd0);
      check_eq("rst_pmem_address", pmem_address_s[d], 32'd0);
    end
    @(negedge clk);

    // Clean read miss
    access(0, 32'h40, 1, 0, 0, 4'h0);
    check_eq("rm_fill_addr", last_fill_addr, 32'h40);
    check_eq("rm_wb_count", 32'(wbs), 32'd0);
    check_eq("rm_rdata", last_rdata, 32'hDEAD_BEEF);
    check_eq("rm_miss_count", miss_count_s[0], 32'd1);
    check_eq("rm_hit_count", hit_count_s[0], 32'd0);

    // Byte-enabled write hits, then read-back
    access(0, 32'h44, 0, 1, 32'h1122_3344, 4'hF);
    check_eq("wh_same_cycle", 32'(last_cycles), 32'd0);
    access(0, 32'h44, 0, 1, 32'hAABB_CCDD, 4'b0101);
    check_eq("wh_be_same_cycle", 32'(last_cycles), 32'd0);
    access(0, 32'h44, 1, 0, 0, 4'h0);
    check_eq("wh_readback", last_rdata, 32'h11BB_33DD);
    check_eq("wh_hit_count", hit_count_s[0], 32'd3);
    access(0, 32'h48, 1, 1, 32'h5A5A_0001, 4'hF);
    access(0, 32'h48, 1, 0, 0, 4'h0);
    check_eq("rw_as_write", last_rdata, 32'h5A5A_0001);
    check_eq("rw_hit_count", hit_count_s[0], 32'd5);

    // Dirty eviction in set 0
    pulse_reset();
    access(0, 32'h000, 1, 0, 0, 4'h0);
    access(0, 32'h000, 0, 1, 32'hCAFE_F00D, 4'hF);
    access(0, 32'h100, 1, 0, 0, 4'h0);
    access(0, 32'h200, 1, 0, 0, 4'h0);
    check_eq("ev_wb_count", 32'(wbs), 32'd1);
    check_eq("ev_wb_first", 32'(wb_first), 32'd1);
    check_eq("ev_wb_addr", last_wb_addr, 32'h000);
    check_eq("ev_fill_addr", last_fill_addr, 32'h200);
    access(0, 32'h000, 1, 0, 0, 4'h0);
    check_eq("ev_wb_data", last_rdata, 32'hCAFE_F00D);
    check_eq("ev_miss_count", miss_count_s[0], 32'd4);

    // Counter clear priority and saturation
    check_eq("cnt_hit_pre", hit_count_s[0], 32'd1);
    hit_clear_s[0] = 1'b1;
    access(0, 32'h000, 1, 0, 0, 4'h0);
    hit_clear_s[0] = 1'b0;
    check_eq("cnt_clear_on_hit", hit_count_s[0], 32'd0);
    force dut0.miss_count_reg = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut0.miss_count_reg;
    access(0, 32'h300, 1, 0, 0, 4'h0);
    check_eq("cnt_miss_sat", miss_count_s[0], 32'hFFFF_FFFF);
    miss_clear_s[0] = 1'b1;
    @(negedge clk);
    miss_clear_s[0] = 1'b0;
    #1;
    check_eq("cnt_miss_clear", miss_count_s[0], 32'd0);
    @(negedge clk);

    // Reset while filling
    mem_address = 32'h500; mem_read_s[0] = 1'b1;
    @(negedge clk); #1;
    check_eq("rf_pmem_read", 32'(pmem_read_s[0]), 32'd1);
    check_eq("rf_pmem_addr", pmem_address_s[0], 32'h500);
    rst = 1'b1;
    #1;
    check_eq("rf_read_drop", 32'(pmem_read_s[0]), 32'd0);
    mem_read_s[0] = 1'b0;
    @(negedge clk); rst = 1'b0;
    access(0, 32'h500, 1, 0, 0, 4'h0);
    check_eq("rf_refill", last_fill_addr, 32'h500);
    check_eq("rf_miss_count", miss_count_s[0], 32'd1);

    // 4-way PLRU: fill, touch 0..3, fifth tag must evict way 0
    for (int i = 0; i < 4; i++) access(1, 32'(i * 32'h100), 1, 0, 0, 4'h0);
    for (int i = 0; i < 4; i++) access(1, 32'(i * 32'h100), 1, 0, 0, 4'h0);
    check_eq("plru_hits", hit_count_s[1], 32'd4);
    access(1, 32'h400, 1, 0, 0, 4'h0);
    check_eq("plru_fill5", last_fill_addr, 32'h400);
    access(1, 32'h104, 1, 0, 0, 4'h0);
    check_eq("plru_way1_kept", hit_count_s[1], 32'd5);
    check_eq("plru_way1_data", last_rdata, 32'h104);
    access(1, 32'h000, 1, 0, 0, 4'h0);
    check_eq("plru_way0_evicted", 32'(fills), 32'd1);
    check_eq("plru_miss_count", miss_count_s[1], 32'd6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d checks, required completion", n_checks);
    $fatal(1, "timeout");
  end

endmodule
